// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - memory-protocol bus (req/gnt request, valid/rdata response)
//
// Purpose: one memory-protocol link between a requester and a responder.
// Signals:
//   req, addr, wdata, be, we : request, driven by the master side
//   gnt                      : request accepted, driven by the slave side
//   valid, rdata             : response, driven by the slave side
// Modports: master (issues requests), slave (accepts requests).
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    we;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, addr, wdata, be, we, input gnt, valid, rdata);
  modport slave  (input req, addr, wdata, be, we, output gnt, valid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-to-one memory-protocol arbiter with in-order response routing
//
// Purpose: shares one memory slave between two masters. One request is
// selected and forwarded combinationally each cycle; the ID of every
// accepted request is queued so in-order responses return to their origin.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   busy_o       : request pending or response outstanding
//   s0_mem       : master 0 link (slave modport)
//   s1_mem       : master 1 link (slave modport)
//   m_mem        : memory link (master modport)
// Options:
//   MEM_ARB_RR_EN     : round-robin on ties (default fixed priority, master 0 wins)
//   MEM_ARB_ASSERT_ON : enables the simulation assertion on responses with no
//                       outstanding request
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                busy_o,
  mem_port_arbiter_if.slave   s0_mem,
  mem_port_arbiter_if.slave   s1_mem,
  mem_port_arbiter_if.master  m_mem
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic                       last_q;

  logic                    full;
  logic                    empty;
  logic                    tie_winner;
  logic                    sel;
  logic                    accept;
  logic                    pop;
  logic                    head;
  logic                    drop_resp;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH/8-1:0] sel_be;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

`ifdef MEM_ARB_RR_EN
  assign tie_winner = ~last_q;
`else
  // last_q keeps updating for visibility but never influences the choice.
  assign tie_winner = last_q & 1'b0;
`endif

  // Idle selects master 0 so its fields appear on the memory bus.
  always_comb begin
    sel = 1'b0;
    if (s0_mem.req && s1_mem.req) begin
      sel = tie_winner;
    end else if (s1_mem.req) begin
      sel = 1'b1;
    end
  end

  assign sel_addr  = sel ? s1_mem.addr  : s0_mem.addr;
  assign sel_wdata = sel ? s1_mem.wdata : s0_mem.wdata;
  assign sel_be    = sel ? s1_mem.be    : s0_mem.be;

  // A full FIFO blocks requests even if a response pops this same cycle.
  assign m_mem.req   = (s0_mem.req | s1_mem.req) & ~full;
  assign m_mem.addr  = sel_addr;
  assign m_mem.wdata = sel_wdata;
  assign m_mem.be    = sel_be;
  assign m_mem.we    = sel ? s1_mem.we : s0_mem.we;

  assign accept     = m_mem.req & m_mem.gnt;
  assign s0_mem.gnt = accept & ~sel;
  assign s1_mem.gnt = accept & sel;

  // Responses with nothing outstanding are discarded.
  assign head         = id_q[rd_ptr_q];
  assign pop          = m_mem.valid & ~empty;
  assign drop_resp    = m_mem.valid & empty;
  assign s0_mem.valid = pop & ~head;
  assign s1_mem.valid = pop & head;
  assign s0_mem.rdata = m_mem.rdata;
  assign s1_mem.rdata = m_mem.rdata;

  assign busy_o = ~empty | s0_mem.req | s1_mem.req;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 1'b1;
    end else begin
      if (accept) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
        last_q         <= sel;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef MEM_ARB_ASSERT_ON
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!drop_resp) else $error("mem_port_arbiter: response with no outstanding request");
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0_bus ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s1_bus ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .busy_o (busy),
    .s0_mem (s0_bus),
    .s1_mem (s1_bus),
    .m_mem  (mem_bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: queue of master IDs awaiting a response, last winner.
  int idq[$];
  bit last_m;
  bit e_sel, e_mreq, e_g0, e_g1, e_v0, e_v1, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [BW-1:0] e_be;
  logic          e_we;

  function automatic logic [5:0] obs_vec();
    return {mem_bus.req, s0_bus.gnt, s1_bus.gnt, s0_bus.valid, s1_bus.valid, busy};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {e_mreq, e_g0, e_g1, e_v0, e_v1, e_busy};
  endfunction

  task automatic model_eval();
    bit r0, r1;
    r0     = s0_bus.req;
    r1     = s1_bus.req;
    e_sel  = (r0 && r1) ? (RR ? !last_m : 1'b0) : r1;
    e_mreq = (r0 || r1) && (idq.size() < MAXO);
    e_g0   = e_mreq && mem_bus.gnt && !e_sel;
    e_g1   = e_mreq && mem_bus.gnt && e_sel;
    e_v0   = mem_bus.valid && (idq.size() > 0) && (idq[0] == 0);
    e_v1   = mem_bus.valid && (idq.size() > 0) && (idq[0] == 1);
    e_busy = (idq.size() != 0) || r0 || r1;
    e_addr  = e_sel ? s1_bus.addr  : s0_bus.addr;
    e_wdata = e_sel ? s1_bus.wdata : s0_bus.wdata;
    e_be    = e_sel ? s1_bus.be    : s0_bus.be;
    e_we    = e_sel ? s1_bus.we    : s0_bus.we;
  endtask

  task automatic model_commit();
    if (mem_bus.valid && idq.size() > 0) void'(idq.pop_front());
    if (e_g0 || e_g1) begin
      idq.push_back(int'(e_sel));
      last_m = e_sel;
    end
  endtask

  task automatic model_reset();
    idq.delete();
    last_m = 1'b1;
  endtask

  task automatic set_m0(input bit req, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, input bit we);
    s0_bus.req = req; s0_bus.addr = a; s0_bus.wdata = d; s0_bus.be = be; s0_bus.we = we;
  endtask

  task automatic set_m1(input bit req, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, input bit we);
    s1_bus.req = req; s1_bus.addr = a; s1_bus.wdata = d; s1_bus.be = be; s1_bus.we = we;
  endtask

  task automatic set_mem(input bit gnt, input bit valid, input logic [DW-1:0] rdata);
    mem_bus.gnt = gnt; mem_bus.valid = valid; mem_bus.rdata = rdata;
  endtask

  task automatic idle_inputs();
    set_m0(1'b0, '0, '0, '0, 1'b0);
    set_m1(1'b0, '0, '0, '0, 1'b0);
    set_mem(1'b0, 1'b0, '0);
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    total_cnt++;
    if (obs_vec() !== 6'b0) $display("FAIL reset_outputs: got %b expected 000000", obs_vec());
    else pass_cnt++;
    total_cnt++;
    if ({mem_bus.addr, mem_bus.wdata, mem_bus.be, mem_bus.we} !== '0)
      $display("FAIL reset_fields: got %0h expected 0", {mem_bus.addr, mem_bus.wdata, mem_bus.be, mem_bus.we});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    apply_reset();
    set_m0(1'b1, 32'h100, '0, 4'hF, 1'b0);
    set_mem(1'b1, 1'b0, '0);
    settle();
    total_cnt++;
    if ({s0_bus.gnt, s1_bus.gnt} !== 2'b10) $display("FAIL single_gnt: got %b expected 10", {s0_bus.gnt, s1_bus.gnt});
    else pass_cnt++;
    total_cnt++;
    if (mem_bus.addr !== 32'h100) $display("FAIL single_addr: got %0h expected 100", mem_bus.addr);
    else pass_cnt++;
    advance();
    set_m0(1'b0, '0, '0, '0, 1'b0);
    set_mem(1'b0, 1'b1, 32'hDEADBEEF);
    settle();
    total_cnt++;
    if ({s0_bus.valid, s1_bus.valid} !== 2'b10 || s0_bus.rdata !== 32'hDEADBEEF)
      $display("FAIL single_resp: got valid=%b rdata=%0h expected valid=10 rdata=deadbeef",
               {s0_bus.valid, s1_bus.valid}, s0_bus.rdata);
    else pass_cnt++;
    advance();
    idle_inputs();
  endtask

  task automatic test_contention();
    bit g1c;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      set_m0(1'b1, 32'h1000 + i, 32'hA0 + i, 4'hF, 1'b0);
      set_m1(1'b1, 32'h2000 + i, 32'hB0 + i, 4'h3, 1'b1);
      set_mem(1'b1, i > 0, 32'h5000 + i);
      settle();
      g1c = RR ? i[0] : 1'b0;
      total_cnt++;
      if ({s0_bus.gnt, s1_bus.gnt} !== {~g1c, g1c})
        $display("FAIL contention_gnt[%0d]: got %b expected %b", i, {s0_bus.gnt, s1_bus.gnt}, {~g1c, g1c});
      else pass_cnt++;
      total_cnt++;
      if (obs_vec() !== exp_vec() || mem_bus.addr !== e_addr)
        $display("FAIL contention_model[%0d]: got %b/%0h expected %b/%0h", i, obs_vec(), mem_bus.addr, exp_vec(), e_addr);
      else pass_cnt++;
      advance();
    end
    idle_inputs();
    set_mem(1'b0, 1'b1, '0);
    settle();
    advance();
    idle_inputs();
  endtask

  task automatic test_full();
    logic [5:0] gnt_tbl;
    logic [5:0] val_tbl;
    gnt_tbl = 6'b100011;
    val_tbl = 6'b010000;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      set_m0(1'b1, 32'h300 + i, '0, 4'hF, 1'b0);
      set_mem(1'b1, val_tbl[i], 32'h77);
      settle();
      total_cnt++;
      if ({mem_bus.req, s0_bus.gnt} !== {gnt_tbl[i], gnt_tbl[i]})
        $display("FAIL full_gnt[%0d]: got %b expected %b", i, {mem_bus.req, s0_bus.gnt}, {gnt_tbl[i], gnt_tbl[i]});
      else pass_cnt++;
      total_cnt++;
      if (obs_vec() !== exp_vec()) $display("FAIL full_model[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      else pass_cnt++;
      advance();
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      set_mem(1'b0, 1'b1, '0);
      settle();
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_interleaved();
    logic [3:0] tbl [5];
    tbl = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b0010};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      case (i)
        0: begin set_m0(1'b1, 32'h40, 32'h1234, 4'hF, 1'b1); set_mem(1'b1, 1'b0, '0); end
        1: begin set_m1(1'b1, 32'h44, '0, 4'hF, 1'b0); set_mem(1'b1, 1'b0, '0); end
        2: begin set_m0(1'b1, 32'h48, '0, 4'hF, 1'b0); set_mem(1'b1, 1'b1, 32'h0); end
        3: begin set_m0(1'b1, 32'h48, '0, 4'hF, 1'b0); set_mem(1'b1, 1'b1, 32'h44AA); end
        default: set_mem(1'b0, 1'b1, 32'h48BB);
      endcase
      settle();
      total_cnt++;
      if ({s0_bus.gnt, s1_bus.gnt, s0_bus.valid, s1_bus.valid} !== tbl[i])
        $display("FAIL interleave[%0d]: got %b expected %b", i,
                 {s0_bus.gnt, s1_bus.gnt, s0_bus.valid, s1_bus.valid}, tbl[i]);
      else pass_cnt++;
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    idle_inputs();
    set_mem(1'b0, 1'b1, 32'hBAD);
    settle();
    total_cnt++;
    if ({s0_bus.valid, s1_bus.valid, dut.drop_resp} !== 3'b001)
      $display("FAIL spurious_drop: got %b expected 001", {s0_bus.valid, s1_bus.valid, dut.drop_resp});
    else pass_cnt++;
    advance();
    idle_inputs();
    settle();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL spurious_busy: got %b expected 0", busy);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_reset_flush();
    apply_reset();
    set_m0(1'b1, 32'h600, '0, 4'hF, 1'b0);
    set_mem(1'b1, 1'b0, '0);
    settle();
    advance();
    idle_inputs();
    settle();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL flush_busy_before: got %b expected 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    model_reset();
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL flush_busy_after: got %b expected 0", busy);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    set_mem(1'b0, 1'b1, 32'h1A7E);
    settle();
    total_cnt++;
    if ({s0_bus.valid, s1_bus.valid, busy} !== 3'b000 || obs_vec() !== exp_vec())
      $display("FAIL flush_late_valid: got %b expected 000", {s0_bus.valid, s1_bus.valid, busy});
    else pass_cnt++;
    advance();
    idle_inputs();
  endtask

  task automatic test_random();
    bit hold0 = 1'b0, hold1 = 1'b0;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      if (!hold0)
        set_m0(($urandom % 3) != 0, $urandom, $urandom, 4'($urandom), 1'($urandom));
      if (!hold1)
        set_m1(($urandom % 3) != 0, $urandom, $urandom, 4'($urandom), 1'($urandom));
      set_mem(($urandom % 4) != 0, (idq.size() > 0) && (($urandom % 2) == 1), $urandom);
      settle();
      total_cnt++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random_ctrl[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      else pass_cnt++;
      total_cnt++;
      if ({mem_bus.addr, mem_bus.wdata, mem_bus.be, mem_bus.we} !== {e_addr, e_wdata, e_be, e_we} ||
          s0_bus.rdata !== mem_bus.rdata || s1_bus.rdata !== mem_bus.rdata)
        $display("FAIL random_data[%0d]: got %0h expected %0h", i,
                 {mem_bus.addr, mem_bus.wdata, mem_bus.be, mem_bus.we}, {e_addr, e_wdata, e_be, e_we});
      else pass_cnt++;
      hold0 = s0_bus.req && !e_g0;
      hold1 = s1_bus.req && !e_g1;
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_read();
    test_contention();
    test_full();
    test_interleaved();
    test_spurious();
    test_reset_flush();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
